// File: rtl/rise_pulse_gen.sv
// Input conditioning: synchronises and debounces a_in into a_filt, then emits
// one-cycle edge pulses and keeps a saturating count of rising events.
module rise_pulse_gen #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned DEBOUNCE    = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_in,
  input  logic             clr_cnt,
  output logic             a_filt,
  output logic             rise_pulse,
  output logic             fall_pulse,
  output logic [CNT_W-1:0] rise_cnt,
  output logic             cnt_sat
);

  localparam int unsigned     DW   = $clog2(DEBOUNCE) + 1;
  localparam logic [DW-1:0]   DMAX = DW'(DEBOUNCE - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;
  logic [DW-1:0]          dcnt;
  logic                   take;
  logic [CNT_W-1:0]       cnt_nxt;

  assign s    = sync_q[SYNC_STAGES-1];
  // a_filt flips on the edge where s has differed for DEBOUNCE consecutive cycles
  assign take = (s != a_filt) && (dcnt == DMAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], a_in};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dcnt   <= '0;
      a_filt <= 1'b0;
    end else if (s == a_filt) begin
      dcnt <= '0;
    end else if (dcnt == DMAX) begin
      a_filt <= s;
      dcnt   <= '0;
    end else begin
      dcnt <= dcnt + DW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_pulse <= 1'b0;
      fall_pulse <= 1'b0;
    end else begin
      rise_pulse <= take & s;
      fall_pulse <= take & ~s;
    end
  end

  always_comb begin
    cnt_nxt = rise_cnt;
    if (clr_cnt) begin
      cnt_nxt = '0;
    end else if (rise_pulse && (rise_cnt != '1)) begin
      cnt_nxt = rise_cnt + CNT_W'(1);
    end
  end

  // cnt_sat is derived from the next count so it lines up with rise_cnt
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rise_cnt <= '0;
      cnt_sat  <= 1'b0;
    end else begin
      rise_cnt <= cnt_nxt;
      cnt_sat  <= &cnt_nxt;
    end
  end

endmodule

// File: tb/tb_rise_pulse_gen.sv
// Directed bench for rise_pulse_gen: default instance plus a 2-bit counter instance.
module tb_rise_pulse_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       a_in = 1'b0;
  logic       clr_cnt = 1'b0;

  logic       a_filt, rise_pulse, fall_pulse, cnt_sat;
  logic [7:0] rise_cnt;
  logic       a_filt2, rise_pulse2, fall_pulse2, cnt_sat2;
  logic [1:0] rise_cnt2;

  logic [11:0] obs;
  logic [5:0]  obs2;

  int n_cmp  = 0;
  int n_fail = 0;

  assign obs  = {a_filt, rise_pulse, fall_pulse, cnt_sat, rise_cnt};
  assign obs2 = {a_filt2, rise_pulse2, fall_pulse2, cnt_sat2, rise_cnt2};

  always #5 clk = ~clk;

  rise_pulse_gen dut (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .clr_cnt(clr_cnt),
    .a_filt(a_filt), .rise_pulse(rise_pulse), .fall_pulse(fall_pulse),
    .rise_cnt(rise_cnt), .cnt_sat(cnt_sat)
  );

  rise_pulse_gen #(.CNT_W(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .a_in(a_in), .clr_cnt(clr_cnt),
    .a_filt(a_filt2), .rise_pulse(rise_pulse2), .fall_pulse(fall_pulse2),
    .rise_cnt(rise_cnt2), .cnt_sat(cnt_sat2)
  );

  a_rose: assert property (@(posedge clk) disable iff (!rst_n) $rose(a_filt) |-> rise_pulse)
    else begin $display("FAIL sva_rose: rise_pulse=%0b required 1", rise_pulse); n_fail++; end
  a_fell: assert property (@(posedge clk) disable iff (!rst_n) $fell(a_filt) |-> fall_pulse)
    else begin $display("FAIL sva_fell: fall_pulse=%0b required 1", fall_pulse); n_fail++; end
  a_excl: assert property (@(posedge clk) disable iff (!rst_n) !(rise_pulse && fall_pulse))
    else begin $display("FAIL sva_excl: rise=%0b fall=%0b required not both", rise_pulse, fall_pulse); n_fail++; end
  a_one: assert property (@(posedge clk) disable iff (!rst_n) rise_pulse |=> !rise_pulse)
    else begin $display("FAIL sva_one: rise_pulse=%0b required 0", rise_pulse); n_fail++; end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) step();
    n_cmp++;
    if (obs !== 12'h000) begin
      $display("FAIL reset: got %h required %h", obs, 12'h000); n_fail++;
    end
    n_cmp++;
    if (obs2 !== 6'h00) begin
      $display("FAIL reset_w2: got %h required %h", obs2, 6'h00); n_fail++;
    end
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_glitch();
    a_in = 1'b1;
    for (int i = 0; i < 13; i++) begin
      if (i == 3) a_in = 1'b0;
      step();
      n_cmp++;
      if (obs !== 12'h000) begin
        $display("FAIL glitch cyc%0d: got %h required %h", i, obs, 12'h000); n_fail++;
      end
    end
  endtask

  task automatic test_rise();
    a_in = 1'b1;
    repeat (5) step();
    n_cmp++;
    if (obs !== 12'h000) begin
      $display("FAIL rise_pre: got %h required %h", obs, 12'h000); n_fail++;
    end
    step();
    n_cmp++;
    if (obs !== {1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      $display("FAIL rise_edge: got %h required %h", obs, {1'b1, 1'b1, 1'b0, 1'b0, 8'd0}); n_fail++;
    end
    step();
    n_cmp++;
    if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd1}) begin
      $display("FAIL rise_post: got %h required %h", obs, {1'b1, 1'b0, 1'b0, 1'b0, 8'd1}); n_fail++;
    end
    n_cmp++;
    if (obs2 !== {1'b1, 1'b0, 1'b0, 1'b0, 2'd1}) begin
      $display("FAIL rise_post_w2: got %h required %h", obs2, {1'b1, 1'b0, 1'b0, 1'b0, 2'd1}); n_fail++;
    end
  endtask

  task automatic test_fall();
    a_in = 1'b0;
    repeat (5) step();
    n_cmp++;
    if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd1}) begin
      $display("FAIL fall_pre: got %h required %h", obs, {1'b1, 1'b0, 1'b0, 1'b0, 8'd1}); n_fail++;
    end
    step();
    n_cmp++;
    if (obs !== {1'b0, 1'b0, 1'b1, 1'b0, 8'd1}) begin
      $display("FAIL fall_edge: got %h required %h", obs, {1'b0, 1'b0, 1'b1, 1'b0, 8'd1}); n_fail++;
    end
    step();
    n_cmp++;
    if (obs !== {1'b0, 1'b0, 1'b0, 1'b0, 8'd1}) begin
      $display("FAIL fall_post: got %h required %h", obs, {1'b0, 1'b0, 1'b0, 1'b0, 8'd1}); n_fail++;
    end
  endtask

  task automatic pulse_a_in();
    a_in = 1'b1;
    repeat (8) step();
    a_in = 1'b0;
    repeat (8) step();
  endtask

  task automatic test_saturate();
    logic [7:0] k8;
    logic [1:0] k2;
    logic       s2;
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    n_cmp++;
    if (obs !== 12'h000 || obs2 !== 6'h00) begin
      $display("FAIL clr: got %h/%h required 000/00", obs, obs2); n_fail++;
    end
    for (int k = 1; k <= 4; k++) begin
      pulse_a_in();
      k8 = 8'(k);
      k2 = (k >= 3) ? 2'd3 : 2'(k);
      s2 = (k >= 3);
      n_cmp++;
      if (obs !== {4'b0000, k8}) begin
        $display("FAIL sat_cnt%0d: got %h required %h", k, obs, {4'b0000, k8}); n_fail++;
      end
      n_cmp++;
      if (obs2 !== {3'b000, s2, k2}) begin
        $display("FAIL sat_cnt%0d_w2: got %h required %h", k, obs2, {3'b000, s2, k2}); n_fail++;
      end
    end
    a_in = 1'b1;
    repeat (6) step();
    n_cmp++;
    if (obs !== {1'b1, 1'b1, 1'b0, 1'b0, 8'd4} || obs2 !== {1'b1, 1'b1, 1'b0, 1'b1, 2'd3}) begin
      $display("FAIL clr_rise_pre: got %h/%h required %h/%h", obs, obs2,
               {1'b1, 1'b1, 1'b0, 1'b0, 8'd4}, {1'b1, 1'b1, 1'b0, 1'b1, 2'd3}); n_fail++;
    end
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    n_cmp++;
    if (obs !== {1'b1, 11'd0} || obs2 !== {1'b1, 5'd0}) begin
      $display("FAIL clr_wins: got %h/%h required %h/%h", obs, obs2, {1'b1, 11'd0}, {1'b1, 5'd0}); n_fail++;
    end
    step();
    n_cmp++;
    if (obs !== {1'b1, 11'd0} || obs2 !== {1'b1, 5'd0}) begin
      $display("FAIL clr_hold: got %h/%h required %h/%h", obs, obs2, {1'b1, 11'd0}, {1'b1, 5'd0}); n_fail++;
    end
    a_in = 1'b0;
    repeat (8) step();
  endtask

  task automatic test_reset_mid();
    pulse_a_in();
    a_in = 1'b1;
    repeat (4) step();
    n_cmp++;
    if (obs !== {4'b0000, 8'd1}) begin
      $display("FAIL mid_pre: got %h required %h", obs, {4'b0000, 8'd1}); n_fail++;
    end
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (obs !== 12'h000 || obs2 !== 6'h00) begin
      $display("FAIL mid_rst: got %h/%h required 000/00", obs, obs2); n_fail++;
    end
    repeat (2) step();
    n_cmp++;
    if (obs !== 12'h000 || obs2 !== 6'h00) begin
      $display("FAIL mid_rst_hold: got %h/%h required 000/00", obs, obs2); n_fail++;
    end
    rst_n = 1'b1;
    repeat (5) step();
    n_cmp++;
    if (obs !== 12'h000) begin
      $display("FAIL mid_rel_pre: got %h required %h", obs, 12'h000); n_fail++;
    end
    step();
    n_cmp++;
    if (obs !== {1'b1, 1'b1, 1'b0, 1'b0, 8'd0}) begin
      $display("FAIL mid_rel_edge: got %h required %h", obs, {1'b1, 1'b1, 1'b0, 1'b0, 8'd0}); n_fail++;
    end
    step();
    n_cmp++;
    if (obs !== {1'b1, 1'b0, 1'b0, 1'b0, 8'd1}) begin
      $display("FAIL mid_rel_post: got %h required %h", obs, {1'b1, 1'b0, 1'b0, 1'b0, 8'd1}); n_fail++;
    end
  endtask

  // Reference model of sync (2) + debounce (4), starting from a settled a_filt=1
  task automatic test_random();
    logic [1:0] m_s = 2'b11;
    int         m_cnt = 0;
    logic       m_filt = 1'b1;
    logic       exp_r, exp_f, a;
    int         rises = 0;
    int         run_left = 0;
    logic [7:0] exp_cnt;
    logic [1:0] exp_cnt2;
    for (int i = 0; i < 212; i++) begin
      if (i >= 200) begin
        a_in = 1'b0;
      end else if (run_left == 0) begin
        a_in = 1'($urandom_range(0, 1));
        run_left = $urandom_range(1, 7);
      end
      if (run_left > 0) run_left--;
      a = a_in;
      step();
      exp_r = 1'b0;
      exp_f = 1'b0;
      if (m_s[1] != m_filt) begin
        if (m_cnt == 3) begin
          exp_r  = m_s[1];
          exp_f  = ~m_s[1];
          m_filt = m_s[1];
          m_cnt  = 0;
        end else begin
          m_cnt++;
        end
      end else begin
        m_cnt = 0;
      end
      m_s = {m_s[0], a};
      if (exp_r) rises++;
      n_cmp++;
      if ({a_filt, rise_pulse, fall_pulse} !== {m_filt, exp_r, exp_f}) begin
        $display("FAIL rand cyc%0d: got %b required %b", i, {a_filt, rise_pulse, fall_pulse},
                 {m_filt, exp_r, exp_f}); n_fail++;
      end
    end
    exp_cnt  = 8'(1 + rises);
    exp_cnt2 = (1 + rises >= 3) ? 2'd3 : 2'(1 + rises);
    n_cmp++;
    if (rise_cnt !== exp_cnt) begin
      $display("FAIL rand_cnt: got %0d required %0d", rise_cnt, exp_cnt); n_fail++;
    end
    n_cmp++;
    if ({cnt_sat2, rise_cnt2} !== {(exp_cnt2 == 2'd3), exp_cnt2}) begin
      $display("FAIL rand_cnt_w2: got %b required %b", {cnt_sat2, rise_cnt2},
               {(exp_cnt2 == 2'd3), exp_cnt2}); n_fail++;
    end
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_rise();
    test_fall();
    test_saturate();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
